// File: rtl/cv32e40s_pkg.sv
// Shared cv32e40s package: SHA-256 sigma constants and helpers, plus the
// message-schedule FSM state type.
package cv32e40s_pkg;

    localparam int unsigned SHA256_SIG0_R1 = 7;
    localparam int unsigned SHA256_SIG0_R2 = 18;
    localparam int unsigned SHA256_SIG0_S  = 3;
    localparam int unsigned SHA256_SIG1_R1 = 17;
    localparam int unsigned SHA256_SIG1_R2 = 19;
    localparam int unsigned SHA256_SIG1_S  = 10;

    typedef enum logic {
        SCHED_LOAD,
        SCHED_EXPAND
    } sha_sched_state_e;

    function automatic logic [31:0] sha256_rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sha256_sig0(input logic [31:0] x);
        return sha256_rotr(x, SHA256_SIG0_R1) ^ sha256_rotr(x, SHA256_SIG0_R2) ^ (x >> SHA256_SIG0_S);
    endfunction

    function automatic logic [31:0] sha256_sig1(input logic [31:0] x);
        return sha256_rotr(x, SHA256_SIG1_R1) ^ sha256_rotr(x, SHA256_SIG1_R2) ^ (x >> SHA256_SIG1_S);
    endfunction

endpackage

// File: rtl/cv32e40s_sha256_sigma.sv
// Combinational SHA-256 small-sigma pair used by the message-schedule expander.
module cv32e40s_sha256_sigma
    import cv32e40s_pkg::*;
(
    input  logic [31:0] sig0_in_i,
    input  logic [31:0] sig1_in_i,
    output logic [31:0] sig0_o,
    output logic [31:0] sig1_o
);

    always_comb begin
        sig0_o = sha256_sig0(sig0_in_i);
        sig1_o = sha256_sig1(sig1_in_i);
    end

endmodule

// File: rtl/cv32e40s_sha256_msg_sched.sv
// SHA-256 message-schedule expander: loads 16 words, then streams W[0..63]
// computed in place over a 16-entry circular buffer.
module cv32e40s_sha256_msg_sched
    import cv32e40s_pkg::*;
#(
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              blk_valid_i,
    output logic              blk_ready_o,
    input  logic [WORD_W-1:0] blk_word_i,
    output logic              w_valid_o,
    input  logic              w_ready_i,
    output logic [WORD_W-1:0] w_o,
    output logic [5:0]        w_idx_o,
    output logic              w_last_o,
    output logic              busy_o
);

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    sha_sched_state_e  state_q, state_d;
    logic [3:0]        load_cnt_q, load_cnt_d;
    logic [5:0]        t_q, t_d;
    logic [WORD_W-1:0] buf_q [16];
    logic [WORD_W-1:0] buf_d [16];

    logic [3:0]        idx_cur, idx_m2, idx_m7, idx_m15;
    logic [WORD_W-1:0] sig0, sig1, w_exp, w_word;
    logic              expand;

    // With t mod 16 as the slot of W[t-16], the taps t-2/t-7/t-15 land at +14/+9/+1.
    always_comb begin
        idx_cur = t_q[3:0];
        idx_m2  = t_q[3:0] + 4'd14;
        idx_m7  = t_q[3:0] + 4'd9;
        idx_m15 = t_q[3:0] + 4'd1;
    end

    cv32e40s_sha256_sigma u_sigma (
        .sig0_in_i (buf_q[idx_m15]),
        .sig1_in_i (buf_q[idx_m2]),
        .sig0_o    (sig0),
        .sig1_o    (sig1)
    );

    always_comb begin
        w_exp  = sig1 + buf_q[idx_m7] + sig0 + buf_q[idx_cur];
        w_word = (t_q < 6'd16) ? buf_q[idx_cur] : w_exp;
        expand = (state_q == SCHED_EXPAND);
    end

    always_comb begin
        blk_ready_o = (state_q == SCHED_LOAD);
        w_valid_o   = expand;
        w_o         = expand ? w_word : '0;
        w_idx_o     = expand ? t_q : '0;
        w_last_o    = expand && (t_q == LAST_T);
        busy_o      = expand || (load_cnt_q != 4'd0);
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        t_d        = t_q;
        buf_d      = buf_q;
        if (rst || flush_i) begin
            state_d    = SCHED_LOAD;
            load_cnt_d = '0;
            t_d        = '0;
        end else begin
            case (state_q)
                SCHED_LOAD: begin
                    if (blk_valid_i) begin
                        buf_d[load_cnt_q] = blk_word_i;
                        if (load_cnt_q == 4'd15) begin
                            state_d    = SCHED_EXPAND;
                            load_cnt_d = '0;
                            t_d        = '0;
                        end else begin
                            load_cnt_d = load_cnt_q + 4'd1;
                        end
                    end
                end
                SCHED_EXPAND: begin
                    if (w_ready_i) begin
                        if (t_q >= 6'd16) begin
                            buf_d[idx_cur] = w_exp;
                        end
                        if (t_q == LAST_T) begin
                            state_d = SCHED_LOAD;
                            t_d     = '0;
                        end else begin
                            t_d = t_q + 6'd1;
                        end
                    end
                end
                default: state_d = SCHED_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SCHED_LOAD;
            load_cnt_q <= '0;
            t_q        <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            t_q        <= t_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_cv32e40s_sha256_msg_sched.sv
// Self-checking bench for the SHA-256 message-schedule expander against a
// straightforward 64-entry schedule model.
module tb_cv32e40s_sha256_msg_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        blk_valid_i;
    logic        blk_ready_o;
    logic [31:0] blk_word_i;
    logic        w_valid_o;
    logic        w_ready_i;
    logic [31:0] w_o;
    logic [5:0]  w_idx_o;
    logic        w_last_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] blk_m [16];
    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];

    always #5 clk = ~clk;

    cv32e40s_sha256_msg_sched #(.ROUNDS(64), .WORD_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .blk_valid_i (blk_valid_i),
        .blk_ready_o (blk_ready_o),
        .blk_word_i  (blk_word_i),
        .w_valid_o   (w_valid_o),
        .w_ready_i   (w_ready_i),
        .w_o         (w_o),
        .w_idx_o     (w_idx_o),
        .w_last_o    (w_last_o),
        .busy_o      (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook schedule recurrence over a full 64-entry array.
    task automatic build_model();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                exp_w[t] = blk_m[t];
            end else begin
                exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                         + exp_w[t-7]
                         + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                         + exp_w[t-16];
            end
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk_m[i] = 32'h0;
        blk_m[0]  = 32'h61626380;
        blk_m[15] = 32'h00000018;
        build_model();
    endtask

    task automatic set_zero();
        for (int i = 0; i < 16; i++) blk_m[i] = 32'h0;
        build_model();
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) blk_m[i] = $urandom;
        build_model();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_blk_ready"}, 32'(blk_ready_o), 32'd1);
        check({tag, "_w_valid"},   32'(w_valid_o),   32'd0);
        check({tag, "_w_o"},       w_o,              32'd0);
        check({tag, "_w_idx"},     32'(w_idx_o),     32'd0);
        check({tag, "_w_last"},    32'(w_last_o),    32'd0);
        check({tag, "_busy"},      32'(busy_o),      32'd0);
    endtask

    // Runs from one negedge to the next; acceptance is decided before the edge.
    task automatic load_words(input int n, input bit gaps);
        int k = 0;
        int cyc = 0;
        bit tog = 1'b1;
        while (k < n && cyc < 500) begin
            cyc++;
            blk_valid_i = gaps ? tog : 1'b1;
            tog = ~tog;
            blk_word_i = blk_valid_i ? blk_m[k] : $urandom;
            if (blk_valid_i) check("load_ready", 32'(blk_ready_o), 32'd1);
            check("load_wvalid", 32'(w_valid_o), 32'd0);
            if (blk_valid_i && blk_ready_o) k++;
            @(negedge clk);
        end
        blk_valid_i = 1'b0;
        if (k < n) check("load_timeout", 32'(k), 32'(n));
    endtask

    task automatic collect(input int n, input bit rnd);
        int k = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [31:0] pw = '0;
        logic [5:0]  pi = '0;
        check("exp_busy", 32'(busy_o), 32'd1);
        while (k < n && cyc < 2000) begin
            cyc++;
            check("w_valid", 32'(w_valid_o), 32'd1);
            if (stalled) begin
                check("stall_w", w_o, pw);
                check("stall_idx", 32'(w_idx_o), 32'(pi));
            end
            w_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (w_ready_i) begin
                check("w_idx", 32'(w_idx_o), 32'(k));
                check("w_word", w_o, exp_w[k]);
                check("w_last", 32'(w_last_o), 32'(k == 63));
                got_w[k] = w_o;
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                pw = w_o;
                pi = w_idx_o;
            end
            @(negedge clk);
        end
        w_ready_i = 1'b0;
        if (k < n) check("collect_timeout", 32'(k), 32'(n));
    endtask

    task automatic full_block(input string tag, input bit gaps, input bit rnd);
        load_words(16, gaps);
        check({tag, "_latency"}, 32'(w_valid_o), 32'd1);
        collect(64, rnd);
        check({tag, "_done_ready"}, 32'(blk_ready_o), 32'd1);
        check({tag, "_done_valid"}, 32'(w_valid_o), 32'd0);
        check({tag, "_done_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        flush_i     = 1'b0;
        blk_valid_i = 1'b0;
        blk_word_i  = '0;
        w_ready_i   = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        set_abc();
        full_block("abc", 1'b0, 1'b0);
        check("abc_w16", got_w[16], 32'h61626380);
        check("abc_w17", got_w[17], 32'h000F0000);
        check("abc_w63", got_w[63], 32'h12B1EDEB);

        full_block("abc_stall", 1'b1, 1'b1);

        set_random();
        load_words(16, 1'b0);
        collect(30, 1'b1);
        check("pre_flush_idx", 32'(w_idx_o), 32'd30);
        flush_i   = 1'b1;
        w_ready_i = 1'b1;
        @(negedge clk);
        flush_i   = 1'b0;
        w_ready_i = 1'b0;
        check_idle("flush");
        set_abc();
        full_block("post_flush", 1'b0, 1'b1);
        check("post_flush_w16", got_w[16], 32'h61626380);

        set_random();
        load_words(7, 1'b0);
        check("mid_load_busy", 32'(busy_o), 32'd1);
        rst         = 1'b1;
        blk_valid_i = 1'b1;
        blk_word_i  = $urandom;
        @(negedge clk);
        rst         = 1'b0;
        blk_valid_i = 1'b0;
        check_idle("mid_rst");
        set_abc();
        full_block("post_rst", 1'b0, 1'b0);

        set_abc();
        full_block("b2b_abc", 1'b0, 1'b0);
        set_zero();
        full_block("b2b_zero", 1'b0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            set_random();
            full_block("rand", r[0], 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
